// File: rtl/mem_write_checker_pkg.sv
// Shared types and helpers for the memory-write checker: FSM state encoding
// and the bit offset of entry i inside the packed expected-value vectors.
package mem_write_checker_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PASS = 2'd2,
    FAIL = 2'd3
  } state_t;

  // Entry 0 sits in the LSBs, so entry i starts at bit i*w.
  function automatic int unsigned entry_lsb(input int unsigned i, input int unsigned w);
    return i * w;
  endfunction

endpackage

// File: rtl/chk_timeout_cnt.sv
// Saturating idle-cycle counter for the checker; term flags TIMEOUT-1.
module chk_timeout_cnt #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic term
);

  localparam int CYC_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CYC_W-1:0] cnt;

  assign term = (cnt == CYC_W'(TIMEOUT - 1));

  // Holds at the terminal value so a write on that cycle cannot wrap it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !term) begin
      cnt <= cnt + CYC_W'(1);
    end
  end

endmodule

// File: rtl/mem_write_checker.sv
// Checks an ordered list of expected data-memory writes with a cycle timeout.
// Optional MEM_WRITE_CHECKER_SKIP_UNMATCHED_EN: ignore writes to other addresses.
module mem_write_checker
  import mem_write_checker_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NUM_EXP = 4,
  parameter int TIMEOUT = 1024,
  localparam int CNT_W  = $clog2(NUM_EXP + 1),
  localparam int IDX_W  = (NUM_EXP > 1) ? $clog2(NUM_EXP) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      mem_write,
  input  logic [ADDR_W-1:0]         data_adr,
  input  logic [DATA_W-1:0]         write_data,
  input  logic [NUM_EXP*ADDR_W-1:0] exp_adr,
  input  logic [NUM_EXP*DATA_W-1:0] exp_data,
  output logic                      done,
  output logic                      pass,
  output logic                      fail,
  output logic                      timeout,
  output logic [CNT_W-1:0]          match_cnt,
  output logic [IDX_W-1:0]          fail_idx,
  output logic [ADDR_W-1:0]         fail_adr,
  output logic [DATA_W-1:0]         fail_data
);

  state_t state, state_n;

  logic [CNT_W-1:0]  match_cnt_n;
  logic              timeout_n;
  logic [IDX_W-1:0]  fail_idx_n;
  logic [ADDR_W-1:0] fail_adr_n;
  logic [DATA_W-1:0] fail_data_n;
  logic              cyc_clr, cyc_en, cyc_term;

  int unsigned       idx;
  logic [ADDR_W-1:0] exp_a;
  logic [DATA_W-1:0] exp_d;
  logic              adr_hit, data_hit;

  chk_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_cyc (
    .clk   (clk),
    .reset (reset),
    .clr   (cyc_clr),
    .en    (cyc_en),
    .term  (cyc_term)
  );

  // match_cnt doubles as the index of the next expected entry.
  always_comb begin
    idx   = (match_cnt < CNT_W'(NUM_EXP)) ? 32'(match_cnt) : 0;
    exp_a = exp_adr[entry_lsb(idx, ADDR_W) +: ADDR_W];
    exp_d = exp_data[entry_lsb(idx, DATA_W) +: DATA_W];
  end

  // In simulation an X/Z on the bus must count as a mismatch.
`ifdef SYNTHESIS
  assign adr_hit  = (data_adr == exp_a);
  assign data_hit = (write_data == exp_d);
`else
  assign adr_hit  = (data_adr === exp_a);
  assign data_hit = (write_data === exp_d);
`endif

  always_comb begin
    state_n     = state;
    match_cnt_n = match_cnt;
    timeout_n   = timeout;
    fail_idx_n  = fail_idx;
    fail_adr_n  = fail_adr;
    fail_data_n = fail_data;
    cyc_clr     = 1'b0;
    cyc_en      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n     = RUN;
          match_cnt_n = '0;
          cyc_clr     = 1'b1;
        end
      end
      RUN: begin
        if (mem_write) begin
          if (adr_hit && data_hit) begin
            match_cnt_n = match_cnt + CNT_W'(1);
            if (match_cnt == CNT_W'(NUM_EXP - 1)) begin
              state_n = PASS;
            end
`ifdef MEM_WRITE_CHECKER_SKIP_UNMATCHED_EN
          end else if (!adr_hit) begin
            // Scratch store to an unrelated address: neither fail nor advance.
            state_n = RUN;
`endif
          end else begin
            state_n     = FAIL;
            fail_idx_n  = IDX_W'(match_cnt);
            fail_adr_n  = data_adr;
            fail_data_n = write_data;
          end
        end else if (cyc_term) begin
          state_n     = FAIL;
          timeout_n   = 1'b1;
          fail_idx_n  = IDX_W'(match_cnt);
          fail_adr_n  = '0;
          fail_data_n = '0;
        end else begin
          cyc_en = 1'b1;
        end
      end
      default: begin
        state_n = state;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      match_cnt <= '0;
      timeout   <= 1'b0;
      fail_idx  <= '0;
      fail_adr  <= '0;
      fail_data <= '0;
    end else begin
      state     <= state_n;
      match_cnt <= match_cnt_n;
      timeout   <= timeout_n;
      fail_idx  <= fail_idx_n;
      fail_adr  <= fail_adr_n;
      fail_data <= fail_data_n;
    end
  end

  assign done = (state == PASS) || (state == FAIL);
  assign pass = (state == PASS);
  assign fail = (state == FAIL);

endmodule

// File: doc/mem_write_checker.md
Name: mem_write_checker

Overview:
- Synthesizable successor to the single-write pass/fail check used on cpu_main benches.
- Watches the data-memory write bus (MemWrite, DataAdr, WriteData) and checks an ordered list of NUM_EXP expected (address, data) writes.
- Also enforces a cycle timeout and latches first-failure diagnostics.
- Sits beside cpu_main in ISim benches and FPGA bring-up tops; drives done/pass/fail LEDs or bench $finish.

Parameters:
- ADDR_W, 32, DataAdr width
- DATA_W, 32, WriteData width
- NUM_EXP, 4, expected writes in sequence (>=1)
- TIMEOUT, 1024, max cycles in RUN before timeout fail (>=1)

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-low; 0 on a rising clk edge resets all state
- start  in  1  pulse: arm checker (IDLE->RUN)
- mem_write  in  1  MemWrite from core
- data_adr  in  ADDR_W  DataAdr from core
- write_data  in  DATA_W  WriteData from core
- exp_adr  in  NUM_EXP*ADDR_W  expected addresses, entry 0 in LSBs
- exp_data  in  NUM_EXP*DATA_W  expected data, entry 0 in LSBs
- done  out  1  in PASS or FAIL
- pass  out  1  all NUM_EXP writes matched in order
- fail  out  1  mismatch or timeout
- timeout  out  1  fail caused by timeout
- match_cnt  out  $clog2(NUM_EXP+1)  writes matched so far
- fail_idx  out  $clog2(NUM_EXP)  entry index at failure
- fail_adr  out  ADDR_W  offending address (0 on timeout)
- fail_data  out  DATA_W  offending data (0 on timeout)

Behaviour:
- Reset (reset==0 at clk edge): state=IDLE; all outputs 0; cycle counter 0. Reset mid-RUN aborts the check; no diagnostics are retained.
- States: IDLE, RUN, PASS, FAIL. PASS and FAIL are sticky until reset.
- IDLE: mem_write is ignored. start=1 -> RUN; idx=0, cyc=0.
- RUN, each edge:
  - mem_write=1 and (data_adr,write_data)==entry[idx]: match_cnt+1, idx+1. If idx==NUM_EXP-1 -> PASS.
  - mem_write=1 with a mismatch: FAIL; capture fail_idx=idx, fail_adr, fail_data.
  - mem_write=0: cyc+1. cyc==TIMEOUT-1 with no write this cycle -> FAIL, timeout=1, fail_idx=idx, fail_adr/fail_data=0.
  - Write and timeout on the same cycle: the write is evaluated first; a match resets nothing but prevents timeout that cycle; cyc still saturates.
- The cycle counter is global since start, not per-write.
- Comparison uses == with X treated as mismatch: a write whose bus holds X/Z fails. This uses the same === style as the existing bench check, applied in sim only; synthesis uses plain equality.
- Latency: outputs update on the edge that samples the deciding write; done is visible the same cycle the FSM enters PASS/FAIL.
- start while in RUN/PASS/FAIL: ignored.
- pass and fail are never both 1.

Optional Feature:
- Macro MEM_WRITE_CHECKER_SKIP_UNMATCHED_EN.
- Defined: in RUN, a write whose address differs from entry[idx] is ignored; it neither fails nor advances. Same address with wrong data still fails. Use this when the program has scratch stores.
- Undefined: any non-matching write fails immediately, as described above.

Decomposition:
- Package mem_write_checker_pkg holds the state enum typedef (IDLE, RUN, PASS, FAIL) and a function to slice entry i from the packed exp vectors.
- One sub-module, chk_timeout_cnt: counter with clear, enable and a terminal flag at TIMEOUT-1, plus the synchronous active-low reset.

Test Plan:
- NUM_EXP=1; exp=(20,2); start; one write (20,2) -> pass=1, done=1, match_cnt=1 on that edge.
- NUM_EXP=3; exp=(20,2),(24,7),(100,1); writes match in order with idle gaps -> pass after the third; match_cnt 1,2,3.
- Same list; second write is (24,8) -> fail=1, fail_idx=1, fail_adr=24, fail_data=8, timeout=0, match_cnt=1.
- TIMEOUT=16; start, no writes -> fail and timeout on cycle 16 after start; fail_adr=0, fail_data=0.
- Reset low for one edge mid-RUN after one match -> all outputs 0, state IDLE; a later start with the full correct sequence -> pass.
- With macro defined: write (64,5) inserted between matches -> ignored, pass still reached. Without macro, the same stimulus -> fail, fail_adr=64.
